// File: rtl/ycconfig_chain.sv
// -----------------------------------------------------------------------------
// ycconfig_chain
//
// Serial configuration chain for a row of NCELLS Morphle Logic cells. Every
// cell owns a 3-bit code. New codes are shifted in serially through one long
// chain. A separate shadow (commit) register drives the decoded per-cell
// controls, so a frame being shifted in never disturbs the row until the
// frame is committed.
//
// Serial protocol (sampled on confclk rise; there is no valid/ready pair):
//   cshift=1  : cbitin enters cell 0 bit 0 and every bit moves one place
//               toward cell NCELLS-1 (cell i bit2 feeds cell i+1 bit0).
//               Cells are sent MSB first, last cell first.
//   ccommit=1 : the shadow loads the chain contents from before this edge.
//               The frame bit counter and cfull clear.
//   both      : the shadow takes the pre-shift chain, the chain shifts, and
//               the counter restarts at 1.
//   AUTOCOMMIT: the shift that completes a frame also loads the shadow with
//               the post-shift chain. This overrides an explicit ccommit on
//               the same edge, and cfull is not set by that wrap.
//
// Parameters:
//   NCELLS     number of cells in the row (>= 1)
//   AUTOCOMMIT 1 = commit automatically on the frame-completing shift
//
// Ports:
//   confclk          configuration clock, rising edge
//   reset_n          asynchronous active-low reset
//   cbitin           serial configuration bit in
//   cshift           shift enable
//   ccommit          commit the chain into the shadow register
//   cbitout          registered last bit of the chain, cascades to next row
//   cfull            a complete frame has arrived since the last commit/reset
//   empty..vmatch1   per-cell decoded controls, bit i belongs to cell i
// -----------------------------------------------------------------------------
module ycconfig_chain #(
  parameter int NCELLS     = 4,
  parameter bit AUTOCOMMIT = 1'b0
) (
  input  logic              confclk,
  input  logic              reset_n,
  input  logic              cbitin,
  input  logic              cshift,
  input  logic              ccommit,
  output logic              cbitout,
  output logic              cfull,
  output logic [NCELLS-1:0] empty,
  output logic [NCELLS-1:0] hblock,
  output logic [NCELLS-1:0] hbypass,
  output logic [NCELLS-1:0] hmatch0,
  output logic [NCELLS-1:0] hmatch1,
  output logic [NCELLS-1:0] vblock,
  output logic [NCELLS-1:0] vbypass,
  output logic [NCELLS-1:0] vmatch0,
  output logic [NCELLS-1:0] vmatch1
);

  localparam int NBITS = 3 * NCELLS;
  localparam int CW    = (NBITS > 1) ? $clog2(NBITS) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(NBITS - 1);

  // Cell i occupies chain[3*i+2 : 3*i]; bit 0 of a cell is the lowest index.
  logic [NBITS-1:0] chain;
  logic [NBITS-1:0] chain_shifted;
  logic [NBITS-1:0] shadow;
  logic [CW-1:0]    bit_cnt;
  logic             frame_wrap;
  logic             auto_commit;

  assign chain_shifted = {chain[NBITS-2:0], cbitin};

  // The shift that carries the last bit of a frame.
  assign frame_wrap  = cshift & (bit_cnt == LAST_BIT);
  assign auto_commit = AUTOCOMMIT & frame_wrap;

  // The serial output is simply the top of the chain, already a flop.
  assign cbitout = chain[NBITS-1];

  // ---------------------------------------------------------------------------
  // Shift chain
  // ---------------------------------------------------------------------------
  always_ff @(posedge confclk or negedge reset_n) begin
    if (!reset_n) begin
      chain <= '0;
    end else if (cshift) begin
      chain <= chain_shifted;
    end
  end

  // ---------------------------------------------------------------------------
  // Shadow register. Auto-commit takes the frame that just completed, which
  // only exists in chain_shifted on this edge; an explicit commit takes the
  // chain as it stood before the edge.
  // ---------------------------------------------------------------------------
  always_ff @(posedge confclk or negedge reset_n) begin
    if (!reset_n) begin
      shadow <= '0;
    end else if (auto_commit) begin
      shadow <= chain_shifted;
    end else if (ccommit) begin
      shadow <= chain;
    end
  end

  // ---------------------------------------------------------------------------
  // Frame bit counter and frame-full flag
  // ---------------------------------------------------------------------------
  always_ff @(posedge confclk or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt <= '0;
      cfull   <= 1'b0;
    end else if (auto_commit) begin
      // The wrap itself is the commit, so the frame is consumed, not full.
      bit_cnt <= '0;
      cfull   <= 1'b0;
    end else if (ccommit) begin
      // A shift on the commit edge is the first bit of the next frame.
      bit_cnt <= cshift ? CW'(1) : '0;
      cfull   <= 1'b0;
    end else if (cshift) begin
      if (frame_wrap) begin
        bit_cnt <= '0;
        cfull   <= 1'b1;
      end else begin
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Per-cell decode of the committed code b2b1b0.
  // ---------------------------------------------------------------------------
  always_comb begin
    empty   = '0;
    hblock  = '0;
    hbypass = '0;
    hmatch0 = '0;
    hmatch1 = '0;
    vblock  = '0;
    vbypass = '0;
    vmatch0 = '0;
    vmatch1 = '0;
    for (int i = 0; i < NCELLS; i++) begin
      case (shadow[3*i +: 3])
        3'b000: begin              // space: blocks both directions
          empty[i]  = 1'b1;
          hblock[i] = 1'b1;
          vblock[i] = 1'b1;
        end
        3'b001: begin              // +: both directions pass
        end
        3'b010: begin              // -: horizontal wire
          vblock[i] = 1'b1;
        end
        3'b011: begin              // |: vertical wire
          hblock[i] = 1'b1;
        end
        3'b100: begin              // 1
          hbypass[i] = 1'b1;
          vmatch1[i] = 1'b1;
        end
        3'b101: begin              // 0
          hbypass[i] = 1'b1;
          vmatch0[i] = 1'b1;
        end
        3'b110: begin              // Y
          vbypass[i] = 1'b1;
          hmatch1[i] = 1'b1;
        end
        default: begin             // N (3'b111)
          vbypass[i] = 1'b1;
          hmatch0[i] = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ycconfig_chain.sv
// -----------------------------------------------------------------------------
// Testbench for ycconfig_chain (NCELLS=4).
//   dut : AUTOCOMMIT=0, main instance
//   dut2: AUTOCOMMIT=0, cascaded from dut.cbitout, shares shift/commit
//   ac  : AUTOCOMMIT=1, independent inputs
// Decoded outputs are packed as
//   {empty, hblock, hbypass, hmatch0, hmatch1, vblock, vbypass, vmatch0, vmatch1}
// -----------------------------------------------------------------------------
module tb_ycconfig_chain;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic confclk = 1'b0;
  always #5 confclk = ~confclk;

  logic reset_n    = 1'b0;
  logic cbitin     = 1'b0;
  logic cshift     = 1'b0;
  logic ccommit    = 1'b0;
  logic ac_cbitin  = 1'b0;
  logic ac_cshift  = 1'b0;
  logic ac_ccommit = 1'b0;

  logic        cbitout, cfull;
  logic        b_cbitout, b_cfull;
  logic        a_cbitout, a_cfull;
  logic [35:0] outs, b_outs, a_outs;

  ycconfig_chain #(.NCELLS(4), .AUTOCOMMIT(1'b0)) dut (
    .confclk(confclk), .reset_n(reset_n), .cbitin(cbitin), .cshift(cshift),
    .ccommit(ccommit), .cbitout(cbitout), .cfull(cfull),
    .empty(outs[35:32]), .hblock(outs[31:28]), .hbypass(outs[27:24]),
    .hmatch0(outs[23:20]), .hmatch1(outs[19:16]), .vblock(outs[15:12]),
    .vbypass(outs[11:8]), .vmatch0(outs[7:4]), .vmatch1(outs[3:0])
  );

  ycconfig_chain #(.NCELLS(4), .AUTOCOMMIT(1'b0)) dut2 (
    .confclk(confclk), .reset_n(reset_n), .cbitin(cbitout), .cshift(cshift),
    .ccommit(ccommit), .cbitout(b_cbitout), .cfull(b_cfull),
    .empty(b_outs[35:32]), .hblock(b_outs[31:28]), .hbypass(b_outs[27:24]),
    .hmatch0(b_outs[23:20]), .hmatch1(b_outs[19:16]), .vblock(b_outs[15:12]),
    .vbypass(b_outs[11:8]), .vmatch0(b_outs[7:4]), .vmatch1(b_outs[3:0])
  );

  ycconfig_chain #(.NCELLS(4), .AUTOCOMMIT(1'b1)) ac (
    .confclk(confclk), .reset_n(reset_n), .cbitin(ac_cbitin), .cshift(ac_cshift),
    .ccommit(ac_ccommit), .cbitout(a_cbitout), .cfull(a_cfull),
    .empty(a_outs[35:32]), .hblock(a_outs[31:28]), .hbypass(a_outs[27:24]),
    .hmatch0(a_outs[23:20]), .hmatch1(a_outs[19:16]), .vblock(a_outs[15:12]),
    .vbypass(a_outs[11:8]), .vmatch0(a_outs[7:4]), .vmatch1(a_outs[3:0])
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [0:0]  exp_q[$];     // expected cbitout, one entry per shift
  logic [11:0] mdl_chain;    // bench copy of the shift chain
  int          mdl_since;    // shifts since last commit/reset
  logic [35:0] exp_outs;     // decode of the last committed frame

  // Cell codes (cell i at [3*i +: 3])
  localparam logic [11:0] FRAME_TP    = {3'b111, 3'b100, 3'b010, 3'b001}; // N,1,-,+
  localparam logic [11:0] FRAME_PLUS  = {4{3'b001}};
  localparam logic [11:0] FRAME_Y     = {4{3'b110}};
  localparam logic [11:0] FRAME_N     = {4{3'b111}};
  localparam logic [11:0] FRAME_MIX   = {3'b110, 3'b101, 3'b011, 3'b000}; // Y,0,|,space
  localparam logic [11:0] FRAME_LONE1 = {3'b100, 3'b000, 3'b000, 3'b000};

  function automatic logic [35:0] exp_vec(input logic [11:0] codes);
    logic [35:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      case (codes[3*i +: 3])
        3'b000: begin r[32+i] = 1'b1; r[28+i] = 1'b1; r[12+i] = 1'b1; end
        3'b001: ;
        3'b010: r[12+i] = 1'b1;
        3'b011: r[28+i] = 1'b1;
        3'b100: begin r[24+i] = 1'b1; r[i]    = 1'b1; end
        3'b101: begin r[24+i] = 1'b1; r[4+i]  = 1'b1; end
        3'b110: begin r[8+i]  = 1'b1; r[16+i] = 1'b1; end
        default: begin r[8+i] = 1'b1; r[20+i] = 1'b1; end
      endcase
    end
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic do_reset();
    @(negedge confclk);
    reset_n = 1'b0;
    cshift = 1'b0; ccommit = 1'b0; cbitin = 1'b0;
    ac_cshift = 1'b0; ac_ccommit = 1'b0; ac_cbitin = 1'b0;
    mdl_chain = '0;
    mdl_since = 0;
    exp_outs  = exp_vec(12'h000);
    exp_q.delete();
    for (int i = 0; i < 11; i++) exp_q.push_back(1'b0);
    @(posedge confclk); #1;
    n_tests++;
    if (outs !== exp_outs) begin
      n_fail++; $display("FAIL reset_outs got %h exp %h", outs, exp_outs);
    end
    n_tests++;
    if (cfull !== 1'b0 || cbitout !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags got cfull=%b cbitout=%b exp 0 0", cfull, cbitout);
    end
    n_tests++;
    if (a_outs !== exp_outs || b_outs !== exp_outs) begin
      n_fail++; $display("FAIL reset_other got a=%h b=%h exp %h", a_outs, b_outs, exp_outs);
    end
    @(negedge confclk);
    reset_n = 1'b1;
  endtask

  task automatic shift_bit(input logic b);
    logic [0:0] e;
    @(negedge confclk);
    cbitin = b; cshift = 1'b1;
    @(posedge confclk); #1;
    cshift = 1'b0;
    mdl_chain = {mdl_chain[10:0], b};
    mdl_since++;
    exp_q.push_back(b);
    e = exp_q.pop_front();
    n_tests++;
    if (cbitout !== e[0]) begin
      n_fail++; $display("FAIL shift_cbitout got %b exp %b", cbitout, e[0]);
    end
    n_tests++;
    if (cfull !== (mdl_since >= 12)) begin
      n_fail++; $display("FAIL shift_cfull got %b exp %b (shift %0d)", cfull, (mdl_since >= 12), mdl_since);
    end
    n_tests++;
    if (outs !== exp_outs) begin
      n_fail++; $display("FAIL shift_outs_held got %h exp %h", outs, exp_outs);
    end
  endtask

  task automatic shift_frame(input logic [11:0] codes);
    for (int c = 3; c >= 0; c--)
      for (int b = 2; b >= 0; b--)
        shift_bit(codes[3*c + b]);
  endtask

  task automatic commit();
    @(negedge confclk);
    ccommit = 1'b1;
    @(posedge confclk); #1;
    ccommit = 1'b0;
    exp_outs  = exp_vec(mdl_chain);
    mdl_since = 0;
    n_tests++;
    if (outs !== exp_outs) begin
      n_fail++; $display("FAIL commit_outs got %h exp %h", outs, exp_outs);
    end
    n_tests++;
    if (cfull !== 1'b0 || cbitout !== mdl_chain[11]) begin
      n_fail++; $display("FAIL commit_flags got cfull=%b cbitout=%b exp 0 %b", cfull, cbitout, mdl_chain[11]);
    end
  endtask

  task automatic ac_shift(input logic b, input logic cm);
    @(negedge confclk);
    ac_cbitin = b; ac_cshift = 1'b1; ac_ccommit = cm;
    @(posedge confclk); #1;
    ac_cshift = 1'b0; ac_ccommit = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 5; i++) shift_bit(1'b1);
    do_reset();   // partial frame discarded
  endtask

  task automatic test_frame();
    shift_frame(FRAME_TP);
    n_tests++;
    if (cfull !== 1'b1) begin
      n_fail++; $display("FAIL frame_cfull got %b exp 1", cfull);
    end
    commit();
    n_tests++;
    if (outs[35:32] !== 4'b0000 || outs[15:12] !== 4'b0010 || outs[27:24] !== 4'b0100 ||
        outs[3:0] !== 4'b0100 || outs[11:8] !== 4'b1000 || outs[23:20] !== 4'b1000) begin
      n_fail++; $display("FAIL frame_decode got %h exp empty=0 vblock=2 hbypass=4 vmatch1=4 vbypass=8 hmatch0=8", outs);
    end
  endtask

  task automatic test_hold();
    for (int i = 0; i < 5; i++) shift_bit(1'($urandom_range(0, 1)));
    for (int k = 0; k < 6; k++) begin
      @(posedge confclk); #1;
      n_tests++;
      if (outs !== exp_outs || cfull !== 1'b0 || cbitout !== mdl_chain[11]) begin
        n_fail++;
        $display("FAIL hold got outs=%h cfull=%b cbitout=%b exp %h 0 %b", outs, cfull, cbitout, exp_outs, mdl_chain[11]);
      end
    end
    // Counter must have held: the frame completes exactly on the 12th shift.
    for (int i = 0; i < 7; i++) shift_bit(1'($urandom_range(0, 1)));
    commit();
  endtask

  task automatic test_cascade();
    do_reset();
    shift_bit(1'b1);
    for (int i = 0; i < 11; i++) shift_bit(1'b0);
    n_tests++;
    if (cbitout !== 1'b1) begin
      n_fail++; $display("FAIL cascade_rise got %b exp 1", cbitout);
    end
    shift_frame(FRAME_MIX);
    commit();
    n_tests++;
    if (b_outs !== exp_vec(FRAME_LONE1)) begin
      n_fail++; $display("FAIL cascade_second got %h exp %h", b_outs, exp_vec(FRAME_LONE1));
    end
    n_tests++;
    if (b_cfull !== 1'b0) begin
      n_fail++; $display("FAIL cascade_second_cfull got %b exp 0", b_cfull);
    end
  endtask

  task automatic test_simultaneous();
    logic [0:0] e;
    do_reset();
    shift_frame(FRAME_PLUS);
    @(negedge confclk);
    cbitin = 1'b1; cshift = 1'b1; ccommit = 1'b1;
    @(posedge confclk); #1;
    cshift = 1'b0; ccommit = 1'b0;
    exp_outs  = exp_vec(mdl_chain);           // pre-shift contents
    mdl_chain = {mdl_chain[10:0], 1'b1};
    mdl_since = 1;
    exp_q.push_back(1'b1);
    e = exp_q.pop_front();
    n_tests++;
    if (outs !== 36'h0) begin
      n_fail++; $display("FAIL simul_outs got %h exp 000000000", outs);
    end
    n_tests++;
    if (cfull !== 1'b0 || cbitout !== e[0]) begin
      n_fail++; $display("FAIL simul_flags got cfull=%b cbitout=%b exp 0 %b", cfull, cbitout, e[0]);
    end
    // Counter restarted at 1: cfull rises on the 11th further shift.
    for (int i = 0; i < 11; i++) shift_bit(1'($urandom_range(0, 1)));
  endtask

  task automatic test_autocommit();
    logic [11:0] pre;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      ac_shift(FRAME_Y[11 - i], 1'b0);
      n_tests++;
      if (i < 11 && (a_outs !== exp_vec(12'h000) || a_cfull !== 1'b0)) begin
        n_fail++; $display("FAIL ac_hold got %h cfull=%b exp %h 0", a_outs, a_cfull, exp_vec(12'h000));
      end
      if (i == 11 && (a_outs[11:8] !== 4'b1111 || a_outs[19:16] !== 4'b1111 ||
                      a_outs !== exp_vec(FRAME_Y) || a_cfull !== 1'b0)) begin
        n_fail++; $display("FAIL ac_commit got %h cfull=%b exp %h 0", a_outs, a_cfull, exp_vec(FRAME_Y));
      end
    end
    // Explicit commit on the wrap edge must lose to the post-shift frame.
    pre = FRAME_Y;
    for (int i = 0; i < 11; i++) begin
      ac_shift(FRAME_N[11 - i], 1'b0);
      pre = {pre[10:0], FRAME_N[11 - i]};
    end
    n_tests++;
    if (a_outs !== exp_vec(FRAME_Y)) begin
      n_fail++; $display("FAIL ac_held got %h exp %h", a_outs, exp_vec(FRAME_Y));
    end
    ac_shift(FRAME_N[0], 1'b1);
    n_tests++;
    if (a_outs !== exp_vec(FRAME_N) || a_cfull !== 1'b0) begin
      n_fail++; $display("FAIL ac_override got %h cfull=%b exp %h 0 (pre-shift would be %h)",
                         a_outs, a_cfull, exp_vec(FRAME_N), exp_vec(pre));
    end
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    test_reset();
    test_frame();
    test_hold();
    test_cascade();
    test_simultaneous();
    test_autocommit();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ycconfig_chain.md
Name: ycconfig_chain

Overview:
- Parametrised successor to the single 3-bit Morphle Logic configuration cell.
- Holds the configuration for a row of NCELLS cells in one serial shift chain, with a shadow (commit) register per cell. Shifting a new frame never disturbs the active decoded controls until the frame is committed.
- Adds a shift enable, a frame bit counter with a frame-full flag, and an optional auto-commit mode.
- Sits between the serial configuration source and a row of yblock cells; cbitout cascades to the next row.

Parameters:
- NCELLS, 4, number of cells in the chain (>=1).
- AUTOCOMMIT, 0, 1 = commit automatically on the shift that completes a frame.

Ports:
- confclk  input  1  configuration clock; rising-edge active.
- reset_n  input  1  asynchronous active-low reset.
- cbitin  input  1  serial configuration bit in.
- cshift  input  1  shift enable, sampled on confclk rise.
- ccommit  input  1  load shadow from shift chain, sampled on confclk rise.
- cbitout  output  1  serial out: last bit of the chain, for cascading.
- cfull  output  1  a complete frame (3*NCELLS shifts) has arrived since the last commit or reset.
- empty  output  NCELLS  per-cell decoded controls; bit i belongs to cell i.
- hblock, hbypass, hmatch0, hmatch1  output  NCELLS each  per-cell decoded horizontal controls.
- vblock, vbypass, vmatch0, vmatch1  output  NCELLS each  per-cell decoded vertical controls.

Behaviour:
- Clocking and reset: one clock, confclk. Reset is asynchronous and active-low on reset_n.
- Reset clears:
  - shift chain (3*NCELLS bits) = 0
  - shadow = 0
  - bit counter = 0
  - cfull = 0
  - cbitout = 0
- Decoded outputs after reset: each cell decodes code 000, so empty=1, hblock=1, vblock=1, all other controls 0.
- Reset asserted mid-frame discards the partial frame. After release, the next shift is bit 0 of a new frame.
- Shift: on a confclk rise with cshift=1, cbitin enters cell 0 bit 0 and every bit moves one place toward cell NCELLS-1.
  - Inside a cell, bits move bit0->bit1->bit2; cell i bit2 feeds cell i+1 bit0.
  - cbitout = cell NCELLS-1 bit2, registered (no combinational path from cbitin).
  - Each cell is sent MSB first. The first 3 bits shifted end in cell NCELLS-1 after a full frame.
  - A bit reaches cbitout 3*NCELLS shifts after entering.
  - cshift=0: chain holds.
- Code per cell (shadow value b2b1b0), all unlisted outputs 0:
  - 000 space: empty, hblock, vblock
  - 001 +: none (both directions pass)
  - 010 -: vblock
  - 011 |: hblock
  - 100 1: hbypass, vmatch1
  - 101 0: hbypass, vmatch0
  - 110 Y: vbypass, hmatch1
  - 111 N: vbypass, hmatch0
- Decoded outputs depend only on the shadow register; they change only on a commit edge.
- Commit: ccommit=1 at a confclk rise copies the shift chain into the shadow.
  - Outputs change after that edge.
  - The bit counter and cfull clear on the same edge.
- Simultaneous cshift=1 and ccommit=1: the shadow captures the pre-shift chain contents, the chain shifts, and the counter restarts at 1.
- Bit counter: range 0..3*NCELLS-1. It increments per shift and wraps to 0 after 3*NCELLS-1.
  - On the wrap, cfull sets and stays set while further shifting continues.
- AUTOCOMMIT=1: on the shift edge where the counter wraps, the shadow loads the post-shift chain value on that same edge.
  - cfull is not set by that wrap.
  - An explicit ccommit on the same edge is ignored; the auto-commit value wins.
- AUTOCOMMIT=0: the shadow changes only on ccommit.
- Counter width: clog2(3*NCELLS), minimum 1 bit.

Test Plan:
- Reset: pulse reset_n low mid-frame (after 5 of 12 shifts, NCELLS=4) -> empty=4'b1111, hblock=vblock=4'b1111, other controls 0, cfull=0, cbitout=0, and the next frame loads correctly from bit 0.
- Frame load and commit: shift 12 bits encoding cells 3..0 = N,1,-,+ (MSB first, cell 3 first) -> outputs unchanged during shifting and cfull=1 after the 12th shift. Then ccommit -> empty=0000, vblock=0010, hbypass=0100, vmatch1=0100, vbypass=1000, hmatch0=1000, cfull=0.
- Cascade timing: shift a lone 1 followed by zeros -> cbitout rises exactly 12 shifts after the 1 was shifted in. Two chained instances: the second holds the first's previous frame after 12 more shifts.
- Enable hold: toggle confclk with cshift=0 and ccommit=0 -> chain, counter, cbitout and outputs unchanged.
- Simultaneous: with a full frame "+" in all cells, assert cshift=1, ccommit=1, cbitin=1 -> outputs decode all "+" (pre-shift), counter=1, cfull=0.
- AUTOCOMMIT=1 instance: shift 12 bits of all "Y" -> on the 12th shift edge vbypass=1111 and hmatch1=1111 with no ccommit; cfull stays 0.
